wb_load_merge_stage: RTL and testbench

- Parametrised writeback stage that registers register-file writes and extracts load data from data-memory responses.
- Adds three things to the basic writeback behaviour:
  - load data arrives over a handshake, a variable number of cycles after issue;
  - misaligned loads that cross an XLEN boundary are merged from two response beats;
  - responses still in flight when a squash occurs are discarded.
- Sits between the memory stage and the register file. Asserts busy_o to stall upstream while a load is outstanding.

---
 rtl/wb_load_merge_stage.sv | 160 ++++++++++++++++
 tb/tb_wb_load_merge_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/wb_load_merge_stage.sv
// wb_load_merge_stage: registered writeback with handshaked load responses,
// two-beat merging of boundary-crossing loads and discard of squashed beats.
module wb_load_merge_stage #(
    parameter int XLEN = 64,
    parameter int BA_W = $clog2(XLEN / 8)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            squash_i,
    input  logic            stall_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] rd_data_i,
    input  logic [4:0]      rd_idx_i,
    input  logic            rd_wr_en_i,
    input  logic            is_load_i,
    input  logic            split_i,
    input  logic [3:0]      mem_width_1h_i,
    input  logic            mem_sign_i,
    input  logic [BA_W-1:0] byte_addr_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic [XLEN-1:0] rd_data_o,
    output logic [4:0]      rd_idx_o,
    output logic            rd_wr_en_o,
    output logic            busy_o,
    output logic            valid_ao
);
    typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI, DONE} state_e;

    state_e          state_q, state_d;
    logic [1:0]      drop_cnt_q, drop_cnt_d;
    logic [4:0]      idx_q, idx_d, out_idx_q, out_idx_d;
    logic [XLEN-1:0] data_q, data_d, lo_q, lo_d, hi_q, hi_d, out_data_q, out_data_d;
    logic            wr_en_q, wr_en_d, load_q, load_d, sign_q, sign_d, split_q, split_d;
    logic            out_wr_q, out_wr_d, out_valid_q, out_valid_d;
    logic [3:0]      width_q, width_d;
    logic [BA_W-1:0] ba_q, ba_d;

    logic                   capture, waiting, discard, accept, fire, sgn;
    logic [1:0]             pending;
    logic [2:0]             cnt;
    logic [6:0]             nbits, shamt;
    logic [XLEN-1:0]        low, zx, ld_data;
    logic signed [XLEN-1:0] sx;

    assign busy_o     = state_q != IDLE;
    assign rd_data_o  = out_data_q;
    assign rd_idx_o   = out_idx_q;
    assign rd_wr_en_o = out_wr_q;
    assign valid_ao   = out_valid_q;

    // Field extraction: left-align the field, then shift back with sign or zero fill.
    always_comb begin
        low     = XLEN'({hi_q & {XLEN{split_q}}, lo_q} >> {ba_q, 3'b000});
        nbits   = width_q == 4'b0001 ? 7'd8 :
                  width_q == 4'b0010 ? 7'd16 :
                  width_q == 4'b0100 ? 7'd32 :
                  (width_q == 4'b1000 && XLEN == 64) ? 7'd64 : 7'd0;
        shamt   = 7'(XLEN) - nbits;
        sgn     = sign_q & ~width_q[3];
        zx      = (low << shamt) >> shamt;
        sx      = $signed(low << shamt) >>> shamt;
        ld_data = nbits == 7'd0 ? '0 : sgn ? XLEN'(sx) : zx;
    end

    always_comb begin
        capture     = valid_i & ~busy_o & ~stall_i & ~squash_i;
        waiting     = state_q == WAIT_LO || state_q == WAIT_HI;
        discard     = dmem_rvalid_i & (drop_cnt_q != 2'd0);
        accept      = dmem_rvalid_i & (drop_cnt_q == 2'd0) & waiting;
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        wr_en_d     = wr_en_q;
        load_d      = load_q;
        sign_d      = sign_q;
        split_d     = split_q;
        width_d     = width_q;
        ba_d        = ba_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        fire        = 1'b0;
        unique case (state_q)
            IDLE: if (capture) begin
                idx_d   = rd_idx_i;
                data_d  = rd_data_i;
                wr_en_d = rd_wr_en_i;
                load_d  = is_load_i;
                sign_d  = mem_sign_i;
                split_d = split_i;
                width_d = mem_width_1h_i;
                ba_d    = byte_addr_i;
                state_d = is_load_i ? WAIT_LO : DONE;
            end
            WAIT_LO: if (squash_i) state_d = IDLE;
                else if (accept) begin
                    lo_d    = dmem_rdata_i;
                    state_d = split_q ? WAIT_HI : DONE;
                end
            WAIT_HI: if (squash_i) state_d = IDLE;
                else if (accept) begin
                    hi_d    = dmem_rdata_i;
                    state_d = DONE;
                end
            DONE: if (squash_i) state_d = IDLE;
                else if (!stall_i) begin
                    state_d = IDLE;
                    fire    = 1'b1;
                end
            default: state_d = IDLE;
        endcase
        // Beats still owed by a squashed load, not counting one accepted this cycle.
        pending     = state_q == WAIT_LO ? {1'b0, ~accept} + {1'b0, split_q} :
                      state_q == WAIT_HI ? {1'b0, ~accept} : 2'd0;
        cnt         = {1'b0, drop_cnt_q} - {2'b00, discard} + ((squash_i & waiting) ? {1'b0, pending} : 3'd0);
        drop_cnt_d  = cnt > 3'd2 ? 2'd2 : cnt[1:0];
        out_wr_d    = fire & wr_en_q & (|idx_q);
        out_valid_d = fire;
        out_data_d  = fire ? (load_q ? ld_data : data_q) : out_data_q;
        out_idx_d   = fire ? idx_q : out_idx_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            drop_cnt_q  <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            wr_en_q     <= 1'b0;
            load_q      <= 1'b0;
            sign_q      <= 1'b0;
            split_q     <= 1'b0;
            width_q     <= '0;
            ba_q        <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_wr_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drop_cnt_q  <= drop_cnt_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            wr_en_q     <= wr_en_d;
            load_q      <= load_d;
            sign_q      <= sign_d;
            split_q     <= split_d;
            width_q     <= width_d;
            ba_q        <= ba_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_wr_q    <= out_wr_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_wb_load_merge_stage.sv
// tb_wb_load_merge_stage: directed checks of 64- and 32-bit writeback stages driven in lockstep.
module tb_wb_load_merge_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, squash, stall, valid, wr_en, is_load, split, sign, rvalid;
    logic [4:0]  idx;
    logic [3:0]  width;
    logic [2:0]  ba;
    logic [63:0] rd_data, rdata;
    logic [63:0] o64_data;
    logic [31:0] o32_data;
    logic [4:0]  o64_idx, o32_idx;
    logic        o64_wr, o32_wr, busy64, busy32, v64, v32;
    int          n_chk = 0, n_pass = 0;

    wb_load_merge_stage #(.XLEN(64)) dut64 (
        .clk_i(clk), .rst_i(rst), .squash_i(squash), .stall_i(stall), .valid_i(valid),
        .rd_data_i(rd_data), .rd_idx_i(idx), .rd_wr_en_i(wr_en), .is_load_i(is_load),
        .split_i(split), .mem_width_1h_i(width), .mem_sign_i(sign), .byte_addr_i(ba),
        .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata), .rd_data_o(o64_data),
        .rd_idx_o(o64_idx), .rd_wr_en_o(o64_wr), .busy_o(busy64), .valid_ao(v64)
    );

    wb_load_merge_stage #(.XLEN(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .squash_i(squash), .stall_i(stall), .valid_i(valid),
        .rd_data_i(rd_data[31:0]), .rd_idx_i(idx), .rd_wr_en_i(wr_en), .is_load_i(is_load),
        .split_i(split), .mem_width_1h_i(width), .mem_sign_i(sign), .byte_addr_i(ba[1:0]),
        .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata[31:0]), .rd_data_o(o32_data),
        .rd_idx_o(o32_idx), .rd_wr_en_o(o32_wr), .busy_o(busy32), .valid_ao(v32)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic issue(input bit ld, input logic [4:0] i, input logic [63:0] d, input bit we,
                         input bit sp, input logic [3:0] w, input bit sg, input logic [2:0] a);
        valid = 1'b1; is_load = ld; idx = i; rd_data = d; wr_en = we;
        split = sp; width = w; sign = sg; ba = a;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d);
        rvalid = 1'b1; rdata = d;
        @(negedge clk);
        rvalid = 1'b0;
    endtask

    task automatic wb_check(input string tag, input bit en, input logic [4:0] i,
                            input logic [63:0] d64, input logic [31:0] d32, input bit both);
        @(negedge clk);
        chk({tag, ".valid"}, v64, 1);
        chk({tag, ".wr"}, o64_wr, en);
        chk({tag, ".idx"}, o64_idx, i);
        chk({tag, ".data"}, o64_data, d64);
        if (both) begin
            chk({tag, ".valid32"}, v32, 1);
            chk({tag, ".data32"}, o32_data, d32);
        end
        @(negedge clk);
        chk({tag, ".pulse"}, {v64, o64_wr}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; squash = 0; stall = 0; valid = 0; wr_en = 0; is_load = 0; split = 0;
        sign = 0; rvalid = 0; idx = 0; width = 0; ba = 0; rd_data = 0; rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst.out", {o64_data, o64_idx, o64_wr, v64, busy64}, 0);
        chk("rst.out32", {o32_data, o32_idx, o32_wr, v32, busy32}, 0);
        rst = 1'b0;

        issue(0, 5, 64'h1234, 1, 0, 4'b0001, 0, 0);
        chk("nl.busy", {busy64, v64}, 2'b10);
        wb_check("nl", 1, 5, 64'h1234, 32'h1234, 1);
        chk("nl.idle", busy64, 0);

        issue(1, 7, 0, 1, 0, 4'b0001, 1, 3);
        repeat (3) @(negedge clk);
        chk("sb.wait", {busy64, v64}, 2'b10);
        beat(64'h0000_0000_8000_0000);
        wb_check("sb", 1, 7, 64'hFFFF_FFFF_FFFF_FF80, 32'hFFFF_FF80, 1);

        issue(1, 7, 0, 1, 0, 4'b0001, 0, 3);
        repeat (3) @(negedge clk);
        beat(64'h0000_0000_8000_0000);
        wb_check("ub", 1, 7, 64'h80, 32'h80, 1);

        issue(1, 8, 0, 1, 1, 4'b0100, 1, 6);
        beat(64'hBEEF_0000_0000_0000);
        @(negedge clk);
        chk("sw.mid", {busy64, v64}, 2'b10);
        beat(64'h0000_0000_0000_00DE);
        wb_check("sw", 1, 8, 64'h0000_0000_00DE_BEEF, 32'h0, 0);

        issue(1, 9, 0, 1, 1, 4'b0001, 0, 0);
        squash = 1'b1;
        @(negedge clk);
        squash = 1'b0;
        chk("sq.drop", dut64.drop_cnt_q, 2);
        chk("sq.busy", busy64, 0);
        beat(64'h11);
        beat(64'h22);
        chk("sq.drained", dut64.drop_cnt_q, 0);
        chk("sq.nowr", {v64, o64_wr, busy64}, 0);
        issue(1, 10, 0, 1, 0, 4'b0001, 0, 0);
        beat(64'h33);
        wb_check("sq3", 1, 10, 64'h33, 32'h33, 1);

        issue(1, 11, 0, 1, 1, 4'b0001, 0, 0);
        squash = 1'b1; rvalid = 1'b1; rdata = 64'h44;
        @(negedge clk);
        squash = 1'b0; rvalid = 1'b0;
        chk("sqb.drop", dut64.drop_cnt_q, 1);
        issue(1, 12, 0, 1, 0, 4'b0001, 0, 0);
        beat(64'h55);
        chk("dp.disc", {dut64.drop_cnt_q, busy64, v64}, 4'b0010);
        beat(64'h66);
        wb_check("dp", 1, 12, 64'h66, 32'h66, 1);

        issue(0, 3, 64'hCAFE, 1, 0, 4'b0001, 0, 0);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("st.hold", {v64, o64_wr, busy64}, 3'b001);
        end
        stall = 1'b0;
        wb_check("st", 1, 3, 64'hCAFE, 32'hCAFE, 1);

        issue(1, 13, 0, 1, 1, 4'b0100, 0, 4);
        beat(64'h1);
        chk("rh.state", dut64.state_q, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rh.out", {o64_data, o64_idx, o64_wr, v64, busy64}, 0);
        chk("rh.fsm", {dut64.state_q, dut64.drop_cnt_q}, 0);

        issue(0, 0, 64'h77, 1, 0, 4'b0001, 0, 0);
        wb_check("x0", 0, 0, 64'h77, 32'h77, 1);

        issue(1, 14, 0, 1, 0, 4'b0010, 0, 2);
        beat(64'hABCD_0000);
        wb_check("h32", 1, 14, 64'hABCD, 32'hABCD, 1);

        issue(1, 15, 0, 1, 0, 4'b1000, 1, 0);
        beat(64'hF234_5678_9ABC_DEF0);
        wb_check("dw", 1, 15, 64'hF234_5678_9ABC_DEF0, 32'h0, 1);

        issue(1, 16, 0, 1, 0, 4'b0011, 1, 0);
        beat(64'hFFFF_FFFF_FFFF_FFFF);
        wb_check("bad", 1, 16, 64'h0, 32'h0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
